// File: rtl/im_loader.sv
// im_loader: boot-time instruction-memory writer; sweeps the memory to zero, then writes a
// big-endian byte stream as 32-bit words from BASE_ADDR. Define IM_LOADER_CHECKSUM_EN for a checksum trailer.
module im_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h3000,
    parameter int unsigned DEPTH     = 4096,
    parameter int unsigned CNT_W     = 13
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    input  logic [7:0]       byte_in,
    input  logic             byte_valid,
    output logic             byte_ready,
    output logic             wr_en,
    output logic [31:0]      wr_addr,
    output logic [31:0]      wr_data,
    output logic             busy,
    output logic             done,
    output logic             cpu_hold,
`ifdef IM_LOADER_CHECKSUM_EN
    output logic             cksum_err,
`endif
    output logic [CNT_W-1:0] words_written
);

    typedef enum logic [1:0] {IDLE, CLEAR, LOAD, DONE} state_t;

    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(DEPTH - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] len_q, len_d;
    logic [CNT_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] words_d;
    logic [23:0]      asm_q, asm_d;
    logic [1:0]       bcnt_q, bcnt_d;
    logic             byte_ready_d, wr_en_d, busy_d, done_d, cpu_hold_d;
    logic [31:0]      wr_addr_d, wr_data_d;

    logic             accept;
    logic [31:0]      word;
    logic [CNT_W-1:0] words_inc;
    logic [31:0]      load_addr;
    logic             err_hold;

    assign accept    = byte_valid && byte_ready;
    assign word      = {asm_q, byte_in};
    assign words_inc = words_written + CNT_W'(1);
    assign load_addr = BASE_ADDR + (32'(words_written) << 2);

`ifdef IM_LOADER_CHECKSUM_EN
    logic [31:0] sum_q, sum_d;
    logic        cks_phase_q, cks_phase_d;
    logic        cksum_err_d;
    assign err_hold = cksum_err;
`else
    assign err_hold = 1'b0;
`endif

    // State and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            len_q         <= '0;
            idx_q         <= '0;
            asm_q         <= '0;
            bcnt_q        <= '0;
            byte_ready    <= 1'b0;
            wr_en         <= 1'b0;
            wr_addr       <= BASE_ADDR;
            wr_data       <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            cpu_hold      <= 1'b1;
            words_written <= '0;
`ifdef IM_LOADER_CHECKSUM_EN
            sum_q         <= '0;
            cks_phase_q   <= 1'b0;
            cksum_err     <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            len_q         <= len_d;
            idx_q         <= idx_d;
            asm_q         <= asm_d;
            bcnt_q        <= bcnt_d;
            byte_ready    <= byte_ready_d;
            wr_en         <= wr_en_d;
            wr_addr       <= wr_addr_d;
            wr_data       <= wr_data_d;
            busy          <= busy_d;
            done          <= done_d;
            cpu_hold      <= cpu_hold_d;
            words_written <= words_d;
`ifdef IM_LOADER_CHECKSUM_EN
            sum_q         <= sum_d;
            cks_phase_q   <= cks_phase_d;
            cksum_err     <= cksum_err_d;
`endif
        end
    end

    // Next-state and next-output logic; values computed here appear on the ports next cycle
    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        idx_d        = idx_q;
        asm_d        = asm_q;
        bcnt_d       = bcnt_q;
        words_d      = words_written;
        byte_ready_d = 1'b0;
        wr_en_d      = 1'b0;
        wr_addr_d    = wr_addr;
        wr_data_d    = wr_data;
        busy_d       = 1'b0;
        done_d       = 1'b0;
        cpu_hold_d   = 1'b1;
`ifdef IM_LOADER_CHECKSUM_EN
        sum_d        = sum_q;
        cks_phase_d  = cks_phase_q;
        cksum_err_d  = cksum_err;
`endif

        unique case (state_q)
            IDLE, DONE: begin
                if (state_q == DONE) begin
                    done_d     = 1'b1;
                    cpu_hold_d = err_hold;
                end
                if (start) begin
                    state_d    = CLEAR;
                    len_d      = (len > DEPTH_CNT) ? DEPTH_CNT : len;
                    idx_d      = '0;
                    bcnt_d     = '0;
                    words_d    = '0;
                    wr_en_d    = 1'b1;
                    wr_addr_d  = BASE_ADDR;
                    wr_data_d  = '0;
                    busy_d     = 1'b1;
                    done_d     = 1'b0;
                    cpu_hold_d = 1'b1;
`ifdef IM_LOADER_CHECKSUM_EN
                    sum_d       = '0;
                    cks_phase_d = 1'b0;
                    cksum_err_d = 1'b0;
`endif
                end
            end

            // idx_q is the word being cleared in the current cycle
            CLEAR: begin
                busy_d = 1'b1;
                if (idx_q == LAST_IDX) begin
                    if (len_q == '0) begin
                        state_d    = DONE;
                        busy_d     = 1'b0;
                        done_d     = 1'b1;
                        cpu_hold_d = 1'b0;
                    end else begin
                        state_d      = LOAD;
                        byte_ready_d = 1'b1;
                    end
                end else begin
                    idx_d     = idx_q + CNT_W'(1);
                    wr_en_d   = 1'b1;
                    wr_addr_d = wr_addr + 32'd4;
                    wr_data_d = '0;
                end
            end

`ifdef IM_LOADER_CHECKSUM_EN
            // Image words, then a 4-byte trailer compared against the running sum
            LOAD: begin
                busy_d       = 1'b1;
                byte_ready_d = 1'b1;
                if (accept) begin
                    bcnt_d = bcnt_q + 2'd1;
                    asm_d  = {asm_q[15:0], byte_in};
                    if (bcnt_q == 2'd3) begin
                        if (cks_phase_q) begin
                            state_d      = DONE;
                            byte_ready_d = 1'b0;
                            busy_d       = 1'b0;
                            done_d       = 1'b1;
                            cksum_err_d  = (word != sum_q);
                            cpu_hold_d   = (word != sum_q);
                        end else begin
                            wr_en_d   = 1'b1;
                            wr_data_d = word;
                            wr_addr_d = load_addr;
                            words_d   = words_inc;
                            sum_d     = sum_q + word;
                            if (words_inc == len_q) begin
                                cks_phase_d = 1'b1;
                            end
                        end
                    end
                end
            end
`else
            // The final write cycle shows words_written == len_q with byte_ready already low
            LOAD: begin
                busy_d       = 1'b1;
                byte_ready_d = 1'b1;
                if (words_written == len_q) begin
                    state_d      = DONE;
                    byte_ready_d = 1'b0;
                    busy_d       = 1'b0;
                    done_d       = 1'b1;
                    cpu_hold_d   = 1'b0;
                end else if (accept) begin
                    bcnt_d = bcnt_q + 2'd1;
                    asm_d  = {asm_q[15:0], byte_in};
                    if (bcnt_q == 2'd3) begin
                        wr_en_d   = 1'b1;
                        wr_data_d = word;
                        wr_addr_d = load_addr;
                        words_d   = words_inc;
                        if (words_inc == len_q) begin
                            byte_ready_d = 1'b0;
                        end
                    end
                end
            end
`endif
        endcase
    end

endmodule

// File: tb/tb_im_loader.sv
// Directed self-checking bench for im_loader: clear sweep, word assembly, gaps, clamping, resets.
module tb_im_loader;

    localparam logic [31:0] BASE  = 32'h3000;
    localparam int          DEPTH = 4096;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [12:0] len = '0;
    logic [7:0]  byte_in = '0;
    logic        byte_valid = 1'b0;
    logic        byte_ready, wr_en, busy, done, cpu_hold;
    logic [31:0] wr_addr, wr_data;
    logic [12:0] words_written;
`ifdef IM_LOADER_CHECKSUM_EN
    logic        cksum_err;
`endif

    int total = 0;
    int bad = 0;
    int tmo = 0;
    int wr_cnt = 0;
    int stray = 0;
    logic [31:0] mem [DEPTH];

    im_loader dut (
        .clk(clk), .reset(reset), .start(start), .len(len),
        .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byte_ready),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy(busy), .done(done), .cpu_hold(cpu_hold),
`ifdef IM_LOADER_CHECKSUM_EN
        .cksum_err(cksum_err),
`endif
        .words_written(words_written)
    );

    always #5 clk = ~clk;

    // Memory model fed by the write port
    always @(negedge clk) begin
        if (reset && wr_en === 1'b1) begin
            wr_cnt++;
            if (wr_addr < BASE || wr_addr >= BASE + 32'(4 * DEPTH) || wr_addr[1:0] != 2'b00)
                stray++;
            else
                mem[int'((wr_addr - BASE) >> 2)] = wr_data;
        end
    end

    task automatic fill_mem();
        for (int i = 0; i < DEPTH; i++) mem[i] = 32'hDEADBEEF;
        wr_cnt = 0;
        stray = 0;
        tmo = 0;
    endtask

    task automatic pulse_start(input logic [12:0] l);
        @(posedge clk); #1;
        start = 1'b1;
        len = l;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic run_clear(output int errs);
        errs = 0;
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            if (wr_en !== 1'b1 || wr_addr !== BASE + 32'(4 * i) || wr_data !== 32'h0 ||
                busy !== 1'b1 || cpu_hold !== 1'b1 || done !== 1'b0) errs++;
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the byte is taken
    task automatic send_byte(input logic [7:0] b, input bit gap);
        bit ok;
        ok = 1'b0;
        byte_in = b;
        byte_valid = 1'b1;
        for (int n = 0; n < 200 && !ok; n++) begin
            @(negedge clk);
            ok = (byte_ready === 1'b1);
            @(posedge clk); #1;
        end
        byte_valid = 1'b0;
        if (!ok) tmo++;
        if (gap) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic send_word(input logic [31:0] w, input bit gap);
        for (int k = 3; k >= 0; k--) send_byte(w[8*k +: 8], gap);
    endtask

    task automatic send_image(input logic [31:0] img[$], input bit gap);
`ifdef IM_LOADER_CHECKSUM_EN
        logic [31:0] s;
        s = '0;
        for (int i = 0; i < img.size(); i++) s += img[i];
`endif
        for (int i = 0; i < img.size(); i++) send_word(img[i], gap);
`ifdef IM_LOADER_CHECKSUM_EN
        send_word(s, gap);
`endif
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 50 && !ok; n++) begin
            @(negedge clk);
            ok = (done === 1'b1);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #12;
        total++; if (byte_ready !== 1'b0) begin bad++; $display("FAIL rst_ready got %b want 0", byte_ready); end
        total++; if (wr_en !== 1'b0) begin bad++; $display("FAIL rst_wr_en got %b want 0", wr_en); end
        total++; if (wr_addr !== BASE) begin bad++; $display("FAIL rst_addr got %h want %h", wr_addr, BASE); end
        total++; if (wr_data !== 32'h0) begin bad++; $display("FAIL rst_data got %h want 0", wr_data); end
        total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL rst_busy_done got %b%b want 00", busy, done); end
        total++; if (cpu_hold !== 1'b1) begin bad++; $display("FAIL rst_hold got %b want 1", cpu_hold); end
        total++; if (words_written !== 13'd0) begin bad++; $display("FAIL rst_words got %0d want 0", words_written); end
        @(posedge clk); #1;
        reset = 1'b1;
        pulse_start(13'd2);
        repeat (10) @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        total++; if (wr_en !== 1'b0 || wr_addr !== BASE) begin bad++; $display("FAIL async_rst_wr got en=%b addr=%h want 0/%h", wr_en, wr_addr, BASE); end
        total++; if (busy !== 1'b0 || cpu_hold !== 1'b1 || byte_ready !== 1'b0) begin bad++; $display("FAIL async_rst_ctl got busy=%b hold=%b ready=%b want 0/1/0", busy, cpu_hold, byte_ready); end
        @(posedge clk); #1;
        reset = 1'b1;
    endtask

    task automatic test_load(input string nm, input bit gap);
        int errs;
        bit ok;
        logic [31:0] img[$];
        img = '{32'h3C080010, 32'h24090005};
        fill_mem();
        pulse_start(13'd2);
        run_clear(errs);
        total++; if (errs != 0) begin bad++; $display("FAIL %s_clear got %0d bad cycles want 0", nm, errs); end
        @(negedge clk);
        total++; if (byte_ready !== 1'b1 || wr_en !== 1'b0) begin bad++; $display("FAIL %s_load_entry got ready=%b wr_en=%b want 1/0", nm, byte_ready, wr_en); end
        @(posedge clk); #1;
        send_image(img, gap);
        wait_done(ok);
        total++; if (!ok || tmo != 0) begin bad++; $display("FAIL %s_done got done=%b timeouts=%0d want 1/0", nm, done, tmo); end
        total++; if (mem[0] !== 32'h3C080010) begin bad++; $display("FAIL %s_word0 got %h want 3c080010", nm, mem[0]); end
        total++; if (mem[1] !== 32'h24090005) begin bad++; $display("FAIL %s_word1 got %h want 24090005", nm, mem[1]); end
        total++; if (mem[2] !== 32'h0 || mem[DEPTH-1] !== 32'h0) begin bad++; $display("FAIL %s_cleared got %h/%h want 0/0", nm, mem[2], mem[DEPTH-1]); end
        total++; if (words_written !== 13'd2) begin bad++; $display("FAIL %s_words got %0d want 2", nm, words_written); end
        total++; if (cpu_hold !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL %s_release got hold=%b busy=%b want 0/0", nm, cpu_hold, busy); end
        total++; if (wr_cnt != DEPTH + 2 || stray != 0) begin bad++; $display("FAIL %s_wr_count got %0d stray=%0d want %0d/0", nm, wr_cnt, stray, DEPTH + 2); end
        errs = 0;
        byte_in = 8'hFF;
        byte_valid = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (byte_ready !== 1'b0) errs++;
        end
        byte_valid = 1'b0;
        total++; if (errs != 0 || wr_cnt != DEPTH + 2) begin bad++; $display("FAIL %s_extra_byte got ready_cycles=%0d writes=%0d want 0/%0d", nm, errs, wr_cnt, DEPTH + 2); end
    endtask

    task automatic test_len0();
        int errs;
        fill_mem();
        pulse_start(13'd0);
        run_clear(errs);
        total++; if (errs != 0) begin bad++; $display("FAIL len0_clear got %0d bad cycles want 0", errs); end
        @(negedge clk);
        total++; if (done !== 1'b1 || byte_ready !== 1'b0 || wr_en !== 1'b0) begin bad++; $display("FAIL len0_done got done=%b ready=%b wr_en=%b want 1/0/0", done, byte_ready, wr_en); end
        total++; if (cpu_hold !== 1'b0 || words_written !== 13'd0) begin bad++; $display("FAIL len0_hold got hold=%b words=%0d want 0/0", cpu_hold, words_written); end
        total++; if (wr_cnt != DEPTH) begin bad++; $display("FAIL len0_wr_count got %0d want %0d", wr_cnt, DEPTH); end
    endtask

    task automatic test_clamp();
        int errs;
        bit ok;
        logic [31:0] img[$];
        for (int k = 0; k < DEPTH; k++) img.push_back(32'hA5000000 + 32'(k));
        fill_mem();
        pulse_start(13'd5000);
        run_clear(errs);
        total++; if (errs != 0) begin bad++; $display("FAIL clamp_clear got %0d bad cycles want 0", errs); end
        @(posedge clk); #1;
        send_image(img, 1'b0);
        wait_done(ok);
        total++; if (!ok || tmo != 0) begin bad++; $display("FAIL clamp_done got done=%b timeouts=%0d want 1/0", done, tmo); end
        total++; if (words_written !== 13'd4096) begin bad++; $display("FAIL clamp_words got %0d want 4096", words_written); end
        total++; if (mem[0] !== 32'hA5000000 || mem[DEPTH-1] !== 32'hA5000FFF) begin bad++; $display("FAIL clamp_ends got %h/%h want a5000000/a5000fff", mem[0], mem[DEPTH-1]); end
        total++; if (wr_cnt != 2 * DEPTH || stray != 0) begin bad++; $display("FAIL clamp_wr_count got %0d stray=%0d want %0d/0", wr_cnt, stray, 2 * DEPTH); end
        total++; if (byte_ready !== 1'b0) begin bad++; $display("FAIL clamp_ready got %b want 0", byte_ready); end
    endtask

    task automatic test_reset_midload();
        int errs;
        bit ok;
        logic [31:0] img[$];
        img = '{32'h3C080010, 32'h24090005};
        fill_mem();
        pulse_start(13'd2);
        run_clear(errs);
        @(posedge clk); #1;
        send_byte(8'h3C, 1'b0);
        send_byte(8'h08, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h10, 1'b0);
        send_byte(8'h24, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        total++; if (words_written !== 13'd0 || busy !== 1'b0 || byte_ready !== 1'b0) begin bad++; $display("FAIL midrst_state got words=%0d busy=%b ready=%b want 0/0/0", words_written, busy, byte_ready); end
        total++; if (cpu_hold !== 1'b1 || done !== 1'b0) begin bad++; $display("FAIL midrst_hold got hold=%b done=%b want 1/0", cpu_hold, done); end
        @(posedge clk); #1;
        reset = 1'b1;
        fill_mem();
        pulse_start(13'd2);
        run_clear(errs);
        total++; if (errs != 0) begin bad++; $display("FAIL reload_clear got %0d bad cycles want 0", errs); end
        @(posedge clk); #1;
        send_image(img, 1'b0);
        wait_done(ok);
        total++; if (!ok || tmo != 0) begin bad++; $display("FAIL reload_done got done=%b timeouts=%0d want 1/0", done, tmo); end
        total++; if (mem[0] !== 32'h3C080010 || mem[1] !== 32'h24090005) begin bad++; $display("FAIL reload_words got %h/%h want 3c080010/24090005", mem[0], mem[1]); end
        total++; if (words_written !== 13'd2) begin bad++; $display("FAIL reload_count got %0d want 2", words_written); end
    endtask

`ifdef IM_LOADER_CHECKSUM_EN
    task automatic test_checksum();
        int errs;
        bit ok;
        logic [31:0] cks [2];
        cks[0] = 32'h60110015;
        cks[1] = 32'h60110016;
        for (int t = 0; t < 2; t++) begin
            fill_mem();
            pulse_start(13'd2);
            run_clear(errs);
            @(posedge clk); #1;
            send_word(32'h3C080010, 1'b0);
            send_word(32'h24090005, 1'b0);
            send_word(cks[t], 1'b0);
            wait_done(ok);
            total++; if (!ok || tmo != 0) begin bad++; $display("FAIL cks%0d_done got done=%b timeouts=%0d want 1/0", t, done, tmo); end
            total++; if (cksum_err !== 1'(t)) begin bad++; $display("FAIL cks%0d_err got %b want %0d", t, cksum_err, t); end
            total++; if (cpu_hold !== 1'(t)) begin bad++; $display("FAIL cks%0d_hold got %b want %0d", t, cpu_hold, t); end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_load("basic", 1'b0);
        test_load("gaps", 1'b1);
        test_len0();
        test_clamp();
        test_reset_midload();
`ifdef IM_LOADER_CHECKSUM_EN
        test_checksum();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
